ga_parents_select: RTL and testbench

//  Parent-selection engine of the GA selection stage. On a start pulse from the selection FSM it runs
//  NUM_PAIRS binary tournaments over the rank-sorted pool memory (address 0 = best chromosome).
//  It reads the winning chromosomes and hands each parent pair to crossover over a valid/ack channel.
//  It returns a done pulse to the selection FSM. The FSM holds the pool read mux on this block for the whole run.

---
 rtl/ga_parents_select_if.sv | 35 +++
 rtl/ga_parents_select.sv | 173 +++++++++++++++++
 tb/tb_ga_parents_select.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ga_parents_select_if.sv
// rtl/ga_parents_select_if.sv - pool read port and crossover pair channel of the parent selector
interface ga_parents_select_if #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned CHROM_W = 32
) ();

   logic               pool_rd_en;
   logic [ADDR_W-1:0]  pool_rd_addr;
   logic [CHROM_W-1:0] pool_rd_data;
   logic               xover_valid;
   logic               xover_ack;
   logic [CHROM_W-1:0] xover_parent_a;
   logic [CHROM_W-1:0] xover_parent_b;

   modport master (
      output pool_rd_en,
      output pool_rd_addr,
      input  pool_rd_data,
      output xover_valid,
      input  xover_ack,
      output xover_parent_a,
      output xover_parent_b
   );

   modport slave (
      input  pool_rd_en,
      input  pool_rd_addr,
      output pool_rd_data,
      input  xover_valid,
      output xover_ack,
      input  xover_parent_a,
      input  xover_parent_b
   );

endinterface

// File: rtl/ga_parents_select.sv
// rtl/ga_parents_select.sv - binary-tournament parent selection over a rank-sorted pool
// Lower pool address means fitter chromosome, so a tournament winner is simply the smaller index.
module ga_parents_select #(
   parameter int unsigned POP_SIZE  = 16,
   parameter int unsigned CHROM_W   = 32,
   parameter int unsigned NUM_PAIRS = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sw_rst,
   input  logic                parents_start_pls,
   output logic                parents_done_pls,
   ga_parents_select_if.master bus
);

   localparam int unsigned     ADDR_W    = $clog2(POP_SIZE);
   localparam int unsigned     PC_W      = $clog2(NUM_PAIRS + 1);
   localparam logic [15:0]     SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [PC_W-1:0] LAST_PAIR = PC_W'(NUM_PAIRS - 1);

   typedef enum logic [2:0] {
      IDLE,
      DRAW_A,
      RD_A,
      DRAW_B,
      RD_B,
      SEND,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [PC_W-1:0]    pair_cnt_q, pair_cnt_d;
   logic [ADDR_W-1:0]  idx_a_q, idx_a_d;
   logic               rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic [CHROM_W-1:0] parent_a_q, parent_a_d;
   logic [CHROM_W-1:0] parent_b_q, parent_b_d;

   logic [15:0]        lfsr_next;
   logic [ADDR_W-1:0]  cand_0;
   logic [ADDR_W-1:0]  cand_1;
   logic [ADDR_W-1:0]  winner;
   logic [ADDR_W-1:0]  winner_b;

   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
   assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   // Draw addresses are registered on entry to DRAW_A/DRAW_B; the LFSR only moves
   // during those states, so lfsr_q here equals the value seen inside the draw cycle.
   assign cand_0   = lfsr_q[ADDR_W-1:0];
   assign cand_1   = lfsr_q[2*ADDR_W-1:ADDR_W];
   assign winner   = (cand_1 < cand_0) ? cand_1 : cand_0;
   assign winner_b = (winner == idx_a_q) ? winner + ADDR_W'(1) : winner;

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      pair_cnt_d = pair_cnt_q;
      idx_a_d    = idx_a_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = '0;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      parent_a_d = parent_a_q;
      parent_b_d = parent_b_q;

      if (state_q == DRAW_A || state_q == DRAW_B) begin
         lfsr_d = lfsr_next;
      end

      case (state_q)
         IDLE: begin
            if (parents_start_pls) begin
               state_d    = DRAW_A;
               pair_cnt_d = '0;
               rd_en_d    = 1'b1;
               rd_addr_d  = winner;
               idx_a_d    = winner;
            end
         end
         DRAW_A: begin
            state_d = RD_A;
         end
         RD_A: begin
            parent_a_d = bus.pool_rd_data;
            state_d    = DRAW_B;
            rd_en_d    = 1'b1;
            rd_addr_d  = winner_b;
         end
         DRAW_B: begin
            state_d = RD_B;
         end
         RD_B: begin
            parent_b_d = bus.pool_rd_data;
            state_d    = SEND;
            valid_d    = 1'b1;
         end
         SEND: begin
            if (bus.xover_ack) begin
               pair_cnt_d = pair_cnt_q + PC_W'(1);
               if (pair_cnt_q == LAST_PAIR) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = DRAW_A;
                  rd_en_d   = 1'b1;
                  rd_addr_d = winner;
                  idx_a_d   = winner;
               end
            end else begin
               valid_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (sw_rst) begin
         state_d    = IDLE;
         lfsr_d     = SEED;
         pair_cnt_d = '0;
         idx_a_d    = '0;
         rd_en_d    = 1'b0;
         rd_addr_d  = '0;
         valid_d    = 1'b0;
         done_d     = 1'b0;
         parent_a_d = '0;
         parent_b_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lfsr_q     <= SEED;
         pair_cnt_q <= '0;
         idx_a_q    <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         parent_a_q <= '0;
         parent_b_q <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         pair_cnt_q <= pair_cnt_d;
         idx_a_q    <= idx_a_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         parent_a_q <= parent_a_d;
         parent_b_q <= parent_b_d;
      end
   end

   assign parents_done_pls   = done_q;
   assign bus.pool_rd_en     = rd_en_q;
   assign bus.pool_rd_addr   = rd_addr_q;
   assign bus.xover_valid    = valid_q;
   assign bus.xover_parent_a = parent_a_q;
   assign bus.xover_parent_b = parent_b_q;

endmodule

// File: tb/tb_ga_parents_select.sv
// tb/tb_ga_parents_select.sv - randomized bench for ga_parents_select against a tournament model
module tb_ga_parents_select;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic sw_rst16, start16, done16;
   logic sw_rst2, start2, done2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ga_parents_select_if #(.ADDR_W(4), .CHROM_W(32)) b16 ();
   ga_parents_select_if #(.ADDR_W(1), .CHROM_W(32)) b2 ();

   ga_parents_select #(.POP_SIZE(16), .CHROM_W(32), .NUM_PAIRS(8), .LFSR_SEED(16'hACE1)) u16 (
      .clk(clk), .rst(rst), .sw_rst(sw_rst16), .parents_start_pls(start16),
      .parents_done_pls(done16), .bus(b16)
   );

   ga_parents_select #(.POP_SIZE(2), .CHROM_W(32), .NUM_PAIRS(64), .LFSR_SEED(16'hACE1)) u2 (
      .clk(clk), .rst(rst), .sw_rst(sw_rst2), .parents_start_pls(start2),
      .parents_done_pls(done2), .bus(b2)
   );

   logic [31:0] pool16 [16];
   logic [31:0] pool2 [2];

   always @(posedge clk) begin
      if (b16.pool_rd_en) b16.pool_rd_data <= pool16[b16.pool_rd_addr];
      if (b2.pool_rd_en) b2.pool_rd_data <= pool2[b2.pool_rd_addr];
   end

   // ack_mode: 0 = low, 1 = high, 2 = random each cycle
   int ack_mode16, ack_mode2;
   always @(posedge clk) begin
      #2;
      b16.xover_ack = (ack_mode16 == 2) ? 1'($urandom_range(0, 1)) : (ack_mode16 == 1);
      b2.xover_ack  = (ack_mode2 == 2) ? 1'($urandom_range(0, 1)) : (ack_mode2 == 1);
   end

   logic [63:0] obs16[$], obs2[$];
   int vrise16[$], done_cyc16[$], done_cyc2[$];
   int viol16 = 0, viol2 = 0;
   logic pv16 = 1'b0;

   always @(negedge clk) begin
      if (b16.xover_valid && b16.xover_ack) obs16.push_back({b16.xover_parent_a, b16.xover_parent_b});
      if (b2.xover_valid && b2.xover_ack) obs2.push_back({b2.xover_parent_a, b2.xover_parent_b});
      if (b16.xover_valid && !pv16) vrise16.push_back(cyc);
      pv16 = b16.xover_valid;
      if (done16) done_cyc16.push_back(cyc);
      if (done2) done_cyc2.push_back(cyc);
      if (b16.xover_valid && b16.pool_rd_en) viol16++;
      if (b2.xover_valid && b2.pool_rd_en) viol2++;
   end

   int n_tests = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int lfsr_step(input int l);
      int b;
      b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      return ((l >> 1) | (b << 15)) & 16'hFFFF;
   endfunction

   // One tournament pair: two draws, second draw bumped past the first winner on collision.
   task automatic model_pair(input int psz, inout int l, output int ia, output int ib);
      int c0, c1;
      c0 = l % psz;
      c1 = (l / psz) % psz;
      ia = (c0 < c1) ? c0 : c1;
      l  = lfsr_step(l);
      c0 = l % psz;
      c1 = (l / psz) % psz;
      ib = (c0 < c1) ? c0 : c1;
      if (ib == ia) ib = (ib + 1) % psz;
      l  = lfsr_step(l);
   endtask

   int m16, m2, st16, st2;
   logic [63:0] t2_exp[$];

   task automatic start_run16();
      @(posedge clk);
      #1;
      start16 = 1'b1;
      st16 = cyc;
      @(posedge clk);
      #1;
      start16 = 1'b0;
   endtask

   task automatic wait_done16(input int budget, input int d0);
      int k = 0;
      while (done_cyc16.size() == d0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("done16_seen", 64'(done_cyc16.size() > d0), 64'(1));
   endtask

   task automatic wait_valid16(input int budget);
      int k = 0;
      @(negedge clk);
      while (!b16.xover_valid && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("valid16_seen", 64'(b16.xover_valid), 64'(1));
   endtask

   task automatic cmp16(input string tag, input int base, input int n, input bit save);
      int ia, ib;
      logic [63:0] e;
      chk({tag, "_npairs"}, 64'(obs16.size() - base), 64'(n));
      for (int i = 0; i < n; i++) begin
         model_pair(16, m16, ia, ib);
         e = {pool16[ia[3:0]], pool16[ib[3:0]]};
         if (save) t2_exp.push_back(e);
         if (base + i < obs16.size()) chk(tag, obs16[base + i], e);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, db, vb, n0, ia, ib;
      logic [31:0] ca, cb, pa, pb;

      rst = 1'b1;
      sw_rst16 = 1'b0; start16 = 1'b0;
      sw_rst2 = 1'b0;  start2 = 1'b0;
      ack_mode16 = 0;  ack_mode2 = 0;
      for (int i = 0; i < 16; i++) pool16[i] = 32'hC0DE_0000 + 32'(i);
      pool2[0] = $urandom;
      pool2[1] = pool2[0] ^ 32'($urandom_range(1, 255));
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      chk("rst_valid", 64'(b16.xover_valid), 64'(0));
      chk("rst_rd_en", 64'(b16.pool_rd_en), 64'(0));
      chk("rst_rd_addr", 64'(b16.pool_rd_addr), 64'(0));
      chk("rst_parents", {b16.xover_parent_a, b16.xover_parent_b}, 64'(0));
      chk("rst_done", 64'(done16), 64'(0));

      // Full run with ack high; a second start mid-run must be ignored.
      m16 = 16'hACE1;
      ack_mode16 = 1;
      base = obs16.size(); db = done_cyc16.size(); vb = vrise16.size();
      start_run16();
      repeat (8) @(posedge clk);
      #1 start16 = 1'b1;
      @(posedge clk);
      #1 start16 = 1'b0;
      wait_done16(400, db);
      repeat (12) @(negedge clk);
      chk("t2_first_valid_cyc", 64'((vrise16.size() > vb) ? vrise16[vb] - st16 : -1), 64'(5));
      chk("t2_done_cyc", 64'((done_cyc16.size() > db) ? done_cyc16[db] - st16 : -1), 64'(41));
      chk("t2_done_count", 64'(done_cyc16.size() - db), 64'(1));
      cmp16("t2_pair", base, 8, 1'b1);

      // Back-pressure on the first pair, then random ack.
      ack_mode16 = 0;
      base = obs16.size(); db = done_cyc16.size();
      start_run16();
      wait_valid16(50);
      ca = b16.xover_parent_a;
      cb = b16.xover_parent_b;
      n0 = obs16.size();
      repeat (10) begin
         @(negedge clk);
         chk("t3_valid_held", 64'(b16.xover_valid), 64'(1));
         chk("t3_parents_held", {b16.xover_parent_a, b16.xover_parent_b}, {ca, cb});
         chk("t3_no_rd", 64'(b16.pool_rd_en), 64'(0));
      end
      chk("t3_no_xfer", 64'(obs16.size()), 64'(n0));
      @(posedge clk);
      #1 ack_mode16 = 1;
      @(negedge clk);
      @(negedge clk);
      chk("t3_next_draw_rd_en", 64'(b16.pool_rd_en), 64'(1));
      chk("t3_valid_dropped", 64'(b16.xover_valid), 64'(0));
      ack_mode16 = 2;
      wait_done16(800, db);
      cmp16("t3_pair", base, 8, 1'b0);

      // Soft reset mid-run, then a new run must replay the fresh-reset sequence.
      ack_mode16 = 2;
      db = done_cyc16.size();
      start_run16();
      repeat (13) @(posedge clk);
      #1 sw_rst16 = 1'b1;
      @(posedge clk);
      #1 sw_rst16 = 1'b0;
      @(negedge clk);
      chk("t5_swrst_valid", 64'(b16.xover_valid), 64'(0));
      chk("t5_swrst_rd_en", 64'(b16.pool_rd_en), 64'(0));
      chk("t5_swrst_parent_a", 64'(b16.xover_parent_a), 64'(0));
      repeat (30) @(negedge clk);
      chk("t5_no_done", 64'(done_cyc16.size()), 64'(db));
      base = obs16.size();
      start_run16();
      wait_done16(800, db);
      chk("t5_npairs", 64'(obs16.size() - base), 64'(t2_exp.size()));
      for (int i = 0; i < t2_exp.size(); i++)
         if (base + i < obs16.size()) chk("t5_pair", obs16[base + i], t2_exp[i]);

      // Hard reset while waiting in SEND clears outputs immediately.
      ack_mode16 = 0;
      start_run16();
      wait_valid16(50);
      rst = 1'b1;
      #1;
      chk("t1_valid_async", 64'(b16.xover_valid), 64'(0));
      chk("t1_rd_en_async", 64'(b16.pool_rd_en), 64'(0));
      chk("t1_parents_async", {b16.xover_parent_a, b16.xover_parent_b}, 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      db = done_cyc16.size();
      repeat (40) @(negedge clk);
      chk("t1_no_done", 64'(done_cyc16.size()), 64'(db));
      chk("t1_idle_valid", 64'(b16.xover_valid), 64'(0));
      chk("t1_idle_rd_addr", 64'(b16.pool_rd_addr), 64'(0));
      m16 = 16'hACE1;
      ack_mode16 = 2;
      base = obs16.size();
      start_run16();
      wait_done16(800, db);
      cmp16("t1_after_pair", base, 8, 1'b0);

      // Two-entry pool: every pair must be the two distinct entries.
      m2 = 16'hACE1;
      ack_mode2 = 2;
      db = done_cyc2.size();
      base = obs2.size();
      @(posedge clk);
      #1 start2 = 1'b1;
      st2 = cyc;
      @(posedge clk);
      #1 start2 = 1'b0;
      begin
         int k = 0;
         while (done_cyc2.size() == db && k < 3000) begin
            @(negedge clk);
            k++;
         end
      end
      chk("t4_done_seen", 64'(done_cyc2.size() - db), 64'(1));
      chk("t4_npairs", 64'(obs2.size() - base), 64'(64));
      for (int i = 0; i < 64; i++) begin
         model_pair(2, m2, ia, ib);
         if (base + i < obs2.size()) begin
            pa = obs2[base + i][63:32];
            pb = obs2[base + i][31:0];
            chk("t4_pair", {pa, pb}, {pool2[ia[0]], pool2[ib[0]]});
            chk("t4_distinct", 64'(pa != pb), 64'(1));
            chk("t4_wrap", 64'(pb), 64'((pa == pool2[1]) ? pool2[0] : pool2[1]));
         end
      end

      chk("rd_during_valid16", 64'(viol16), 64'(0));
      chk("rd_during_valid2", 64'(viol2), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
